// File: rtl/isp_stream_pkg.sv
// Shared definitions for the ISP YUV output stream: packing modes, FIFO entry
// tag layout, statistics width and the write-side frame FSM encoding.
package isp_stream_pkg;

  // Packing modes for the output word.
  localparam int unsigned MODE_YUV444 = 0;
  localparam int unsigned MODE_YUV422 = 1;

  // Tag bits sit directly above the data field: entry = {sof, eol, data}.
  // These are offsets from the data width W.
  localparam int unsigned EOL_BIT = 0;
  localparam int unsigned SOF_BIT = 1;

  // Width of the saturating dropped-frame counter.
  localparam int unsigned DROP_CNT_W = 16;

  // Write-side frame state.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrop
  } wr_state_e;

  // Packed word width for a given mode and component width.
  function automatic int unsigned word_width(input int unsigned mode, input int unsigned bits);
    return ((mode == MODE_YUV422) ? 2 : 3) * bits;
  endfunction

endpackage

// File: rtl/isp_sync_fifo_ram.sv
// Single-clock FIFO storage: entry array, read/write pointers and fill counter.
// Reads are combinational from the read pointer; the consumer registers them.
module isp_sync_fifo_ram #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      fill_level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  // Full is judged before any same-cycle pop, so a push into a full array is lost.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rd_data = mem[rd_ptr_q];
  assign fill_level = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed: the pointers define what is valid.
  always_ff @(posedge pclk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/isp_yuv_frame_fifo.sv
// Frame-aware YUV output buffer: packs pixels, tags start-of-frame and
// end-of-line, drops whole frames on overflow and presents a valid/ready
// output register to the downstream consumer.
module isp_yuv_frame_fifo
  import isp_stream_pkg::*;
#(
  parameter int unsigned BITS       = 8,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned MODE       = 0,
  parameter int unsigned AFULL_LVL  = DEPTH - 16,
  parameter int unsigned AEMPTY_LVL = 16,
  localparam int unsigned W  = word_width(MODE, BITS),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  in_href,
  input  logic                  in_vsync,
  input  logic [BITS-1:0]       in_y,
  input  logic [BITS-1:0]       in_u,
  input  logic [BITS-1:0]       in_v,
  input  logic                  out_ready,
  input  logic                  clr_stat,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic [AW:0]           fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf_sticky,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned EW         = W + 2;
  localparam logic [AW:0] AFULL_THR  = AFULL_LVL[AW:0];
  localparam logic [AW:0] AEMPTY_THR = AEMPTY_LVL[AW:0];

  wr_state_e state_q, state_d;

  logic          vsync_q;
  logic          parity_q, parity_d;
  logic          armed_q, armed_d;
  logic          hold_valid_q, hold_valid_d;
  logic          hold_sof_q, hold_sof_d;
  logic [W-1:0]  hold_data_q, hold_data_d;
  logic [W-1:0]  pix_word;

  logic          vsync_rise, capture, overflow, wr_en, load;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          ram_full, ram_empty;

  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_entry_q, out_entry_d;

  // Pack the incoming pixel; in 422 the chroma alternates U/V by line parity.
  if (MODE == MODE_YUV422) begin : g_pack_422
    assign pix_word = {in_y, parity_q ? in_v : in_u};
  end else begin : g_pack_444
    assign pix_word = {in_y, in_u, in_v};
  end

  assign vsync_rise = in_vsync && !vsync_q;
  // A held pixel always leaves the hold stage on the following edge.
  assign overflow   = hold_valid_q && ram_full;
  assign wr_en      = hold_valid_q && !ram_full;
  // eol marks a pixel flushed by href falling or by a new frame starting.
  assign wr_entry   = {hold_sof_q, !in_href || vsync_rise, hold_data_q};
  assign capture    = in_href && (state_d == StRun);

  // Write-side frame FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (vsync_rise) state_d = StRun;
      // A new frame starting in the same cycle takes precedence over dropping.
      StRun:   if (overflow && !vsync_rise) state_d = StDrop;
      StDrop:  if (vsync_rise) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // Hold stage, sof arming and 422 chroma parity: next state.
  always_comb begin
    hold_valid_d = capture;
    hold_data_d  = hold_data_q;
    hold_sof_d   = hold_sof_q;
    if (capture) begin
      hold_data_d = pix_word;
      hold_sof_d  = armed_q || vsync_rise;
    end
    armed_d  = (armed_q || vsync_rise) && !capture;
    // Parity restarts whenever href is low, i.e. at each line start.
    parity_d = in_href && !parity_q;
  end

  // Overflow statistics; clear wins over a same-cycle increment.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_stat) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (overflow) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  // Output register: refill when empty or when the current word is taken.
  assign load = (!out_valid_q || out_ready) && !ram_empty;

  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_entry_d = rd_entry;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers for the write side, statistics and output stage.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      parity_q     <= 1'b0;
      armed_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_sof_q   <= 1'b0;
      hold_data_q  <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= in_vsync;
      parity_q     <= parity_d;
      armed_q      <= armed_d;
      hold_valid_q <= hold_valid_d;
      hold_sof_q   <= hold_sof_d;
      hold_data_q  <= hold_data_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
    end
  end

  isp_sync_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_entry),
    .rd_en      (load),
    .rd_data    (rd_entry),
    .fill_level (fill_level),
    .full       (ram_full),
    .empty      (ram_empty)
  );

  assign out_valid    = out_valid_q;
  assign out_data     = out_entry_q[W-1:0];
  assign out_sof      = out_entry_q[W+SOF_BIT];
  assign out_eol      = out_entry_q[W+EOL_BIT];
  assign almost_full  = (fill_level >= AFULL_THR);
  assign almost_empty = (fill_level <= AEMPTY_THR);
  assign ovf_sticky   = ovf_q;
  assign drop_cnt     = drop_q;

endmodule
